// File: rtl/soc_system_pio_in_irq_if.sv
// Avalon-MM slave bus for the input PIO: register select, write strobe and
// registered read data.
interface soc_system_pio_in_irq_if;
    // A write takes effect on any clock edge that samples chipselect=1 and write_n=0.
    // There are no wait states. readdata is registered: after each edge it holds the
    // register that address selected at that edge, whether or not chipselect was set.
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_in_irq.sv
// Parametrised input PIO: per-bit synchroniser, optional debounce, edge capture
// with write-1-to-clear, and a maskable level interrupt.
module soc_system_pio_in_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    soc_system_pio_in_irq_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_RAW     = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] deb_q;

            // Any cycle where s agrees with deb restarts the count, so a bounce
            // back to the old level throws away the partial count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb_q <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (s[i] == deb_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            deb_q[i] <= s[i];
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign deb = deb_q;
        end else begin : g_no_debounce
            assign deb = s;
        end
    endgenerate

    always_comb begin
        case (EDGE_TYPE)
            1:       edge_det = ~deb & deb_d;
            2:       edge_det = deb ^ deb_d;
            default: edge_det = deb & ~deb_d;
        endcase
    end

    assign clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

    // The set term is OR-ed in after the clear so a same-cycle edge always survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d        <= '0;
            cap          <= '0;
            mask         <= '0;
            bus.readdata <= '0;
        end else begin
            deb_d <= deb;
            cap   <= (cap & ~clr) | edge_det;
            if (wr_en && bus.address == ADDR_MASK) mask <= bus.writedata[WIDTH-1:0];
            case (bus.address)
                ADDR_DATA:    bus.readdata <= 32'(deb);
                ADDR_MASK:    bus.readdata <= 32'(mask);
                ADDR_RAW:     bus.readdata <= 32'(s);
                default:      bus.readdata <= 32'(cap);
            endcase
        end
    end

    assign irq = |(cap & mask);
endmodule
